// File: rtl/pong_vram_dp_if.sv
// Bus bundle for the pong video RAM: CPU port (s1) and video scan port (s2).
interface pong_vram_dp_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] s1_address;
  logic              s1_chipselect;
  logic              s1_read;
  logic              s1_write;
  logic [DATA_W-1:0] s1_writedata;
  logic              s1_waitrequest;
  logic [DATA_W-1:0] s1_readdata;
  logic              s1_readdatavalid;
  logic [ADDR_W-1:0] s2_address;
  logic              s2_read;
  logic [DATA_W-1:0] s2_readdata;
  logic              s2_readdatavalid;

  modport master (
    output s1_address, s1_chipselect, s1_read, s1_write, s1_writedata,
    input  s1_waitrequest, s1_readdata, s1_readdatavalid,
    output s2_address, s2_read,
    input  s2_readdata, s2_readdatavalid
  );

  modport slave (
    input  s1_address, s1_chipselect, s1_read, s1_write, s1_writedata,
    output s1_waitrequest, s1_readdata, s1_readdatavalid,
    input  s2_address, s2_read,
    output s2_readdata, s2_readdatavalid
  );
endinterface

// File: rtl/pong_vram_dp.sv
// Pong video RAM: CPU read/write port, never-stalled video read port and a
// clear engine that fills the whole memory with CLEAR_VALUE after reset or on
// request. The CPU port stalls while clearing; the video port sees CLEAR_VALUE.
module pong_vram_dp #(
  parameter int              DATA_W      = 8,
  parameter int              DEPTH       = 96,
  parameter int              ADDR_W      = 7,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  pong_vram_dp_if.slave bus,
  input  logic          clear_req,
  output logic          busy
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;

  logic              s1_in_range, s2_in_range;
  logic              s1_wr_acc, s1_rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // State and clear pointer register; reset restarts the clear from word 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Next state: clear walks the pointer to the last word, then idles until requested.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (ptr_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          ptr_next   = '0;
        end
      end
    endcase
  end

  assign busy               = (state_reg == ST_CLEAR);
  assign bus.s1_waitrequest = busy;

  assign s1_in_range = {1'b0, bus.s1_address} < DEPTH_EXT;
  assign s2_in_range = {1'b0, bus.s2_address} < DEPTH_EXT;
  // A write wins over a simultaneous read; the read is simply dropped.
  assign s1_wr_acc   = bus.s1_chipselect & bus.s1_write & ~busy;
  assign s1_rd_acc   = bus.s1_chipselect & bus.s1_read & ~bus.s1_write & ~busy;

  // Single write port shared by the clear engine and the CPU (mutually exclusive by state).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.s1_address;
    mem_wdata = bus.s1_writedata;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_reg;
      mem_wdata = CLEAR_VALUE;
    end else if (s1_wr_acc && s1_in_range) begin
      mem_we = 1'b1;
    end
  end

  // Memory array write; contents are only defined once a clear has completed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // CPU read port: one-cycle latency, data held between strobes, 0 beyond DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.s1_readdatavalid <= 1'b0;
      bus.s1_readdata      <= '0;
    end else begin
      bus.s1_readdatavalid <= s1_rd_acc;
      if (s1_rd_acc) begin
        bus.s1_readdata <= s1_in_range ? mem[bus.s1_address] : '0;
      end
    end
  end

  // Video read port: read-before-write against a same-cycle CPU write; CLEAR_VALUE while clearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.s2_readdatavalid <= 1'b0;
      bus.s2_readdata      <= '0;
    end else begin
      bus.s2_readdatavalid <= bus.s2_read;
      if (bus.s2_read) begin
        if (busy) begin
          bus.s2_readdata <= CLEAR_VALUE;
        end else begin
          bus.s2_readdata <= s2_in_range ? mem[bus.s2_address] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_vram_dp.sv
// Bench for pong_vram_dp: two instances (CLEAR_VALUE 0x00 and 0x20) share one
// stimulus stream; a behavioural model is compared against both every cycle,
// plus a directed vector table and hand-written clear/reset sequences.
module tb_pong_vram_dp;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 96;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear_req = 1'b0;
  logic busy0, busy1;

  pong_vram_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  pong_vram_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  always #5 clk = ~clk;

  assign bus1.s1_address    = bus0.s1_address;
  assign bus1.s1_chipselect = bus0.s1_chipselect;
  assign bus1.s1_read       = bus0.s1_read;
  assign bus1.s1_write      = bus0.s1_write;
  assign bus1.s1_writedata  = bus0.s1_writedata;
  assign bus1.s2_address    = bus0.s2_address;
  assign bus1.s2_read       = bus0.s2_read;

  pong_vram_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_VALUE(8'h00)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .clear_req(clear_req), .busy(busy0));
  pong_vram_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_VALUE(8'h20)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .clear_req(clear_req), .busy(busy1));

  // ---------------- reference model ----------------
  logic [7:0] cv [2] = '{8'h00, 8'h20};
  logic [7:0] m_mem [2][DEPTH];
  int         m_left = DEPTH;          // clear words still to write; 0 means idle
  logic       m_rdv1 = 1'b0, m_rdv2 = 1'b0;
  logic [7:0] m_rd1 [2] = '{8'h00, 8'h00};
  logic [7:0] m_rd2 [2] = '{8'h00, 8'h00};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= DEPTH;
      m_rdv1 <= 1'b0;
      m_rdv2 <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_rd1[k] <= 8'h00;
        m_rd2[k] <= 8'h00;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_rdv1 <= 1'b0;
      m_rdv2 <= bus0.s2_read;
      for (int k = 0; k < 2; k++) begin
        m_mem[k][7'(DEPTH - m_left)] <= cv[k];
        if (bus0.s2_read) m_rd2[k] <= cv[k];
      end
    end else begin
      m_rdv2 <= bus0.s2_read;
      m_rdv1 <= bus0.s1_chipselect & bus0.s1_read & ~bus0.s1_write;
      for (int k = 0; k < 2; k++) begin
        if (bus0.s2_read)
          m_rd2[k] <= (int'(bus0.s2_address) < DEPTH) ? m_mem[k][bus0.s2_address] : 8'h00;
        if (bus0.s1_chipselect && bus0.s1_write && int'(bus0.s1_address) < DEPTH)
          m_mem[k][bus0.s1_address] <= bus0.s1_writedata;
        if (bus0.s1_chipselect && bus0.s1_read && !bus0.s1_write)
          m_rd1[k] <= (int'(bus0.s1_address) < DEPTH) ? m_mem[k][bus0.s1_address] : 8'h00;
      end
      if (clear_req) m_left <= DEPTH;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy0", 8'(busy0), 8'(m_left > 0));
      chk("busy1", 8'(busy1), 8'(m_left > 0));
      chk("wait0", 8'(bus0.s1_waitrequest), 8'(m_left > 0));
      chk("wait1", 8'(bus1.s1_waitrequest), 8'(m_left > 0));
      chk("s1_rdv0", 8'(bus0.s1_readdatavalid), 8'(m_rdv1));
      chk("s1_rdv1", 8'(bus1.s1_readdatavalid), 8'(m_rdv1));
      chk("s1_rd0", bus0.s1_readdata, m_rd1[0]);
      chk("s1_rd1", bus1.s1_readdata, m_rd1[1]);
      chk("s2_rdv0", 8'(bus0.s2_readdatavalid), 8'(m_rdv2));
      chk("s2_rdv1", 8'(bus1.s2_readdatavalid), 8'(m_rdv2));
      chk("s2_rd0", bus0.s2_readdata, m_rd2[0]);
      chk("s2_rd1", bus1.s2_readdata, m_rd2[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus0.s1_address    = '0;
    bus0.s1_chipselect = 1'b0;
    bus0.s1_read       = 1'b0;
    bus0.s1_write      = 1'b0;
    bus0.s1_writedata  = '0;
    bus0.s2_address    = '0;
    bus0.s2_read       = 1'b0;
    clear_req          = 1'b0;
  endtask

  // Counts consecutive negedge samples with busy high, starting now.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy0 && n < 200) begin
      n++;
      if (n > 1 && bus1.s2_readdatavalid) chk({name, "_s2clr"}, bus1.s2_readdata, 8'h20);
      @(negedge clk);
    end
    chk({name, "_cycles"}, 8'(n), 8'(DEPTH));
    $display("clear %s: busy for %0d cycles", name, n);
  endtask

  task automatic s1_op(input bit wr, input bit rd, input logic [6:0] a, input logic [7:0] d);
    bus0.s1_chipselect = 1'b1;
    bus0.s1_write      = wr;
    bus0.s1_read       = rd;
    bus0.s1_address    = a;
    bus0.s1_writedata  = d;
    @(negedge clk);
    bus0.s1_chipselect = 1'b0;
    bus0.s1_write      = 1'b0;
    bus0.s1_read       = 1'b0;
  endtask

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b0, 7'd0,   8'h00, 8'h00};
    tbl[1] = '{1'b0, 7'd47,  8'h00, 8'h00};
    tbl[2] = '{1'b0, 7'd95,  8'h00, 8'h00};
    tbl[3] = '{1'b1, 7'd10,  8'hA5, 8'h00};
    tbl[4] = '{1'b0, 7'd10,  8'h00, 8'hA5};
    tbl[5] = '{1'b1, 7'd100, 8'hFF, 8'h00};
    tbl[6] = '{1'b0, 7'd100, 8'h00, 8'h00};
    tbl[7] = '{1'b1, 7'd20,  8'h11, 8'h00};
    tbl[8] = '{1'b0, 7'd20,  8'h00, 8'h11};
    tbl[9] = '{1'b0, 7'd127, 8'h00, 8'h00};

    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_busy", 8'(busy0), 8'h01);
    chk("rst_wait", 8'(bus0.s1_waitrequest), 8'h01);
    chk("rst_rd1", bus0.s1_readdata, 8'h00);
    chk("rst_rdv2", 8'(bus0.s2_readdatavalid), 8'h00);
    reset_n = 1'b1;
    count_busy("power_on");

    // Directed vector table on the CLEAR_VALUE=0 instance.
    for (int i = 0; i < 10; i++) begin
      s1_op(tbl[i].wr, !tbl[i].wr, tbl[i].addr, tbl[i].data);
      if (!tbl[i].wr) begin
        chk("tbl_rdv", 8'(bus0.s1_readdatavalid), 8'h01);
        chk("tbl_rd", bus0.s1_readdata, tbl[i].exp);
      end
      $display("vec %0d: %s addr=%0d data=%0h readdata=%0h", i, tbl[i].wr ? "WR" : "RD",
               tbl[i].addr, tbl[i].data, bus0.s1_readdata);
    end

    // Read and write together: write wins, no read strobe.
    s1_op(1'b1, 1'b1, 7'd40, 8'h5A);
    chk("rw_no_rdv", 8'(bus0.s1_readdatavalid), 8'h00);
    s1_op(1'b0, 1'b1, 7'd40, 8'h00);
    chk("rw_rd", bus0.s1_readdata, 8'h5A);
    $display("rw collision: addr 40 readback %0h", bus0.s1_readdata);

    // Same-cycle CPU write and video read of one address: video sees old data.
    bus0.s2_read = 1'b1;
    bus0.s2_address = 7'd20;
    s1_op(1'b1, 1'b0, 7'd20, 8'h3C);
    chk("s2_old", bus0.s2_readdata, 8'h11);
    @(negedge clk);
    bus0.s2_read = 1'b0;
    chk("s2_new", bus0.s2_readdata, 8'h3C);
    $display("video collision: old 11 then %0h", bus0.s2_readdata);

    // Clear request together with a CPU write, then a write held off by waitrequest.
    clear_req = 1'b1;
    s1_op(1'b1, 1'b0, 7'd30, 8'h99);
    clear_req = 1'b0;
    bus0.s1_chipselect = 1'b1;
    bus0.s1_write = 1'b1;
    bus0.s1_address = 7'd5;
    bus0.s1_writedata = 8'h77;
    bus0.s2_read = 1'b1;
    bus0.s2_address = 7'd5;
    count_busy("requested");
    @(negedge clk);
    idle_inputs();
    s1_op(1'b0, 1'b1, 7'd5, 8'h00);
    chk("held_wr0", bus0.s1_readdata, 8'h77);
    chk("held_wr1", bus1.s1_readdata, 8'h77);
    s1_op(1'b0, 1'b1, 7'd30, 8'h00);
    chk("clr_over0", bus0.s1_readdata, 8'h00);
    chk("clr_over1", bus1.s1_readdata, 8'h20);
    $display("after clear: addr5=%0h addr30=%0h/%0h", 8'h77, bus0.s1_readdata, bus1.s1_readdata);

    // Reset in the middle of a clear with a video read in flight.
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    bus0.s2_read = 1'b1;
    repeat (50) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 8'(busy0), 8'h01);
    chk("midrst_rdv2", 8'(bus0.s2_readdatavalid), 8'h00);
    chk("midrst_rd2", bus1.s2_readdata, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus0.s2_read = 1'b0;
    count_busy("after_reset");

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus0.s1_chipselect = 1'($urandom_range(0, 1));
      bus0.s1_read       = 1'($urandom_range(0, 1));
      bus0.s1_write      = 1'($urandom_range(0, 1));
      bus0.s1_address    = 7'($urandom_range(0, 127));
      bus0.s1_writedata  = 8'($urandom);
      bus0.s2_read       = 1'($urandom_range(0, 1));
      bus0.s2_address    = 7'($urandom_range(0, 127));
      clear_req          = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    idle_inputs();
    repeat (100) @(negedge clk);
    $display("random phase done: 3000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_vram_dp.md
PONG_VRAM_DP -- requirements
Module: pong_vram_dp

Interface
REQ-001 Parameter DATA_W, default 8, width of each memory word and both data buses.
REQ-002 Parameter DEPTH, default 96, number of words, legal addresses 0..DEPTH-1.
REQ-003 Parameter ADDR_W, default 7, address width, SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 Parameter CLEAR_VALUE, default 0, word written by the clear engine.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 s1_address  in  ADDR_W  CPU port word address.
REQ-008 s1_chipselect  in  1  CPU port select.
REQ-009 s1_read  in  1  CPU read request, qualified by s1_chipselect.
REQ-010 s1_write  in  1  CPU write request, qualified by s1_chipselect.
REQ-011 s1_writedata  in  DATA_W  CPU write data.
REQ-012 s1_waitrequest  out  1  CPU stall; request not accepted while high.
REQ-013 s1_readdata  out  DATA_W  CPU read data.
REQ-014 s1_readdatavalid  out  1  one-cycle strobe marking valid s1_readdata.
REQ-015 s2_address  in  ADDR_W  video scan port address, read-only.
REQ-016 s2_read  in  1  video read request, never stalled.
REQ-017 s2_readdata  out  DATA_W  video read data.
REQ-018 s2_readdatavalid  out  1  one-cycle strobe marking valid s2_readdata.
REQ-019 clear_req  in  1  single-cycle pulse requesting a full memory clear.
REQ-020 busy  out  1  high while the clear engine runs.

Function
REQ-021 Two-state FSM: CLEAR and IDLE; reset enters CLEAR with clear pointer 0.
REQ-022 CLEAR: each cycle write CLEAR_VALUE at pointer, increment pointer; after writing DEPTH-1 go to IDLE next edge, so CLEAR lasts exactly DEPTH cycles.
REQ-023 IDLE: clear_req=1 enters CLEAR next edge with pointer 0; clear_req in CLEAR is ignored (no restart).
REQ-024 busy = 1 exactly when state is CLEAR; s1_waitrequest = busy (combinational from state only).
REQ-025 CPU write accepted when s1_chipselect & s1_write & ~s1_waitrequest; memory updated at that edge.
REQ-026 CPU read accepted when s1_chipselect & s1_read & ~s1_waitrequest; s1_readdatavalid high the following cycle with data at that address.
REQ-027 s1_read and s1_write both high: write performed, read ignored, no readdatavalid.
REQ-028 s2 read accepted every cycle s2_read=1; s2_readdatavalid high next cycle; in CLEAR returned data is CLEAR_VALUE regardless of memory.
REQ-029 Read latency 1 cycle on both ports; readdata holds last value when readdatavalid is low.
REQ-030 CPU write and video read to same address in same cycle: video returns old (pre-write) data.
REQ-031 CPU read of address just written in previous cycle returns new data.
REQ-032 Address >= DEPTH: writes dropped, reads return 0 with normal readdatavalid timing.
REQ-033 clear_req in IDLE in same cycle as accepted CPU write: write performed, then overwritten by clear.
REQ-034 Clear pointer width ADDR_W; no wrap past DEPTH-1.

Reset
REQ-035 reset_n low asynchronously forces: state CLEAR, pointer 0, busy 1, s1_waitrequest 1, both readdatavalid 0, both readdata 0.
REQ-036 Memory contents not reset directly; defined only after clear completes.
REQ-037 Reset asserted mid-clear or mid-read: pending readdatavalid dropped, clear restarts from address 0 after release.

Verification
REQ-038 Release reset, DEPTH=96 -> busy high exactly 96 cycles, then s1 read of addresses 0, 47, 95 each return 0x00 one cycle after accept.
REQ-039 Idle: s1 write 0xA5 to 10, next cycle s1 read 10 -> s1_readdatavalid one cycle later, s1_readdata=0xA5.
REQ-040 Same cycle s1 write 0x3C to 20 (old 0x11) and s2 read 20 -> s2_readdata=0x11; next s2 read 20 -> 0x3C.
REQ-041 clear_req in IDLE with CLEAR_VALUE=0x20 -> busy high 96 cycles, s1 write held by waitrequest then accepted, s2 reads during clear return 0x20.
REQ-042 s1 write 0xFF to address 100 then read 100 -> readdata 0x00, no memory word changed.
REQ-043 Assert reset_n at pointer 50 of a clear -> busy stays 1, after release full 96-cycle clear from address 0.
